// File: rtl/bnn_pkg.sv
// Shared definitions for the BNN controller instruction path.
//   OPC_HALT / OPC_MSB / OPC_LSB : HALT opcode and where the opcode sits in an instruction
//   *_DEF                        : default widths and buffer depth for the fetch unit
//   fetch_state_t                : instruction sequencer states
//   is_halt()                    : opcode test on a 16-bit instruction word
package bnn_pkg;

  localparam int INST_W_DEF     = 16;
  localparam int ADDR_W_DEF     = 16;
  localparam int FIFO_DEPTH_DEF = 4;

  localparam int         OPC_MSB  = 15;
  localparam int         OPC_LSB  = 11;
  localparam logic [4:0] OPC_HALT = 5'b11111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  function automatic logic is_halt(input logic [15:0] word);
    return word[OPC_MSB:OPC_LSB] == OPC_HALT;
  endfunction

endpackage

// File: rtl/bnn_inst_fifo.sv
// Synchronous instruction buffer holding {pc, inst} entries.
//   clk, rst   : clock, asynchronous active-low reset
//   push/data  : write an entry at the tail (caller guarantees room, or a pop in the same cycle)
//   pop        : drop the head entry (caller only pops when valid)
//   flush      : empty the buffer; takes priority over push and pop
//   head/valid : head entry, read straight from the storage registers
//   count      : number of stored entries (0..DEPTH)
module bnn_inst_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [W-1:0]             head,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      // Full buffer with push and pop together: the head is read before the
      // edge and the tail slot (same index) is overwritten at the edge.
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign valid = (cnt != '0);
  assign count = cnt;

endmodule

// File: rtl/bnn_inst_fetch.sv
// Instruction sequencer: fetches instructions from the instruction SRAM,
// buffers them and presents them to the decoder.
//   clk, rst              : clock, asynchronous active-low reset
//   start, start_pc       : begin fetching at start_pc (ignored while busy / in the done cycle)
//   busy, done            : run in progress; one-cycle pulse when HALT reached and buffer drained
//   isram_en/addr/rdata   : SRAM read port, rdata valid one cycle after isram_en
//   inst_valid/inst/pc    : buffer head offered to the decoder
//   inst_ready            : decoder accepts the head
//   redirect, redirect_pc : decoder took a JUMP; flush and refetch from redirect_pc
//   state                 : current sequencer state (debug)
//
// Handshake: an instruction transfers on a cycle where inst_valid & inst_ready
// are both high. While inst_valid is high and inst_ready low, inst and inst_pc
// hold. The transfer in a redirect cycle is the JUMP itself and counts as done.
module bnn_inst_fetch
  import bnn_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int INST_W     = INST_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  output logic              busy,
  output logic              done,
  output logic              isram_en,
  output logic [ADDR_W-1:0] isram_addr,
  input  logic [INST_W-1:0] isram_rdata,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output fetch_state_t      state
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [ADDR_W-1:0]        fetch_pc;
  logic [ADDR_W-1:0]        resp_pc;   // address of the response due this cycle
  logic [CW-1:0]            inflight;  // 0 or 1 outstanding SRAM read
  logic [CW-1:0]            count;
  logic [ADDR_W+INST_W-1:0] head;

  logic         pop;
  logic         redir_act;
  logic         resp_live;
  logic         resp_halt;
  logic         push;
  logic         halt_hit;
  logic         issue;
  logic [CW:0]  occupancy;

  assign pop       = inst_valid & inst_ready;
  assign redir_act = redirect & (state != IDLE);

  // A response is only used in RUN and when no redirect kills it; anything
  // arriving in DRAIN belongs to addresses past the HALT.
  assign resp_live = (inflight != '0) && (state == RUN) && !redir_act;
  assign resp_halt = is_halt(isram_rdata[15:0]);
  assign push      = resp_live && !resp_halt;
  assign halt_hit  = resp_live && resp_halt;

  // Entries that will occupy the buffer after this edge if nothing new is issued.
  assign occupancy = {1'b0, count} + {1'b0, inflight} - {{CW{1'b0}}, pop};

  assign issue = (state == RUN) && !redir_act && !halt_hit &&
                 (occupancy < (CW+1)'(FIFO_DEPTH));

  assign isram_en   = issue;
  assign isram_addr = fetch_pc;

  bnn_inst_fifo #(
    .W     (ADDR_W + INST_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({resp_pc, isram_rdata}),
    .pop       (pop),
    .flush     (redir_act),
    .head      (head),
    .valid     (inst_valid),
    .count     (count)
  );

  assign {inst_pc, inst} = head;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      fetch_pc <= '0;
      resp_pc  <= '0;
      inflight <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done     <= 1'b0;
      inflight <= issue ? CW'(1) : '0;
      if (issue) begin
        resp_pc  <= fetch_pc;
        fetch_pc <= fetch_pc + ADDR_W'(1);  // wraps at the top of the address space
      end
      case (state)
        IDLE: begin
          // done is high in the cycle after the run ended; a start there is dropped.
          if (start && !done) begin
            state    <= RUN;
            fetch_pc <= start_pc;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          if (redir_act)     fetch_pc <= redirect_pc;
          else if (halt_hit) state    <= DRAIN;
        end
        DRAIN: begin
          if (redir_act) begin
            state    <= RUN;
            fetch_pc <= redirect_pc;
          end else if ((count == '0) && (inflight == '0)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_inst_fetch.sv
// Directed bench for bnn_inst_fetch with an SRAM model and an expected-instruction queue.
module tb_bnn_inst_fetch;
  import bnn_pkg::*;

  localparam int DEPTH = 4;
  localparam logic [15:0] HALT = 16'hF800;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic         start = 1'b0;
  logic [15:0]  start_pc = '0;
  logic         busy, done, isram_en, inst_valid;
  logic [15:0]  isram_addr, inst, inst_pc;
  logic [15:0]  isram_rdata = '0;
  logic         inst_ready = 1'b1;
  logic         redirect = 1'b0;
  logic [15:0]  redirect_pc = '0;
  fetch_state_t dut_state;

  bnn_inst_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .start_pc    (start_pc),
    .busy        (busy),
    .done        (done),
    .isram_en    (isram_en),
    .isram_addr  (isram_addr),
    .isram_rdata (isram_rdata),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .state       (dut_state)
  );

  // ---------------- SRAM model ----------------
  logic [15:0] sram [0:65535];
  always @(posedge clk) if (isram_en) isram_rdata <= sram[isram_addr];

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_prog(input logic [15:0] pc, input logic [15:0] base, input int n);
    logic [15:0] a;
    for (int k = 0; k < n; k++) begin
      a = pc + 16'(k);
      sram[a] = base + 16'(k);
    end
    a = pc + 16'(n);
    sram[a] = HALT;
  endtask

  task automatic exp_run(input logic [15:0] pc, input logic [15:0] base, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back({pc + 16'(k), base + 16'(k)});
  endtask

  // One run as seen by a decoder: start in iteration 0, optional initial stall,
  // optional random ready, optional one-shot JUMP, until done or budget.
  task automatic run_prog(input logic [15:0] pc0, input bit rand_ready, input int hold0,
                          input bit jump_en, input logic [15:0] jump_pc, input logic [15:0] jump_to,
                          input bit start_on_done,
                          output int first_valid, output int first_en,
                          output logic [15:0] first_addr, output int done_at);
    int   occ;
    bit   jmp;
    logic pop;
    logic ok;
    first_valid = -1; first_en = -1; first_addr = '0; done_at = -1;
    occ = 0; jmp = jump_en;
    for (int i = 0; i < 200 && done_at < 0; i++) begin
      @(negedge clk);
      start    = (i == 0) || (rand_ready && i == 4);
      start_pc = (i == 0) ? pc0 : 16'h0040;
      if (i < hold0)       inst_ready = 1'b0;
      else if (rand_ready) inst_ready = 1'($urandom_range(0, 1));
      else                 inst_ready = 1'b1;
      #1;
      redirect    = jmp && inst_valid && inst_ready && (inst_pc == jump_pc);
      redirect_pc = jump_to;
      if (redirect) jmp = 1'b0;
      #1;
      pop = inst_valid & inst_ready;
      if (inst_valid) begin
        if (first_valid < 0) first_valid = i;
        check("head", {inst_pc, inst}, (exp_q.size() != 0) ? exp_q[0] : 32'hDEAD_BEEF);
        if (inst_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (isram_en) begin
        if (first_en < 0) begin first_en = i; first_addr = isram_addr; end
        ok = (occ - int'(pop)) < DEPTH;
        check("issue_cap", 32'(ok), 32'd1);
      end
      occ = redirect ? 0 : occ + int'(isram_en) - int'(pop);
      if (done) begin
        done_at = i;
        check("busy_at_done", 32'(busy), 32'd0);
        if (start_on_done) begin start = 1'b1; start_pc = 16'h0010; end
      end else if (i > 0) begin
        check("busy_run", 32'(busy), 32'd1);
      end
    end
    redirect = 1'b0;
    check("done_seen", 32'(done_at >= 0), 32'd1);
    check("all_delivered", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fv, fe, da;
    logic [15:0] fa;

    for (int a = 0; a < 65536; a++) sram[a] = HALT;
    load_prog(16'h0010, 16'h0800, 6);
    load_prog(16'h0020, 16'h0900, 2);
    load_prog(16'hFFFE, 16'h0A00, 3);

    // reset values
    repeat (2) @(negedge clk);
    #2;
    check("rst_busy",  32'(busy), 0);
    check("rst_done",  32'(done), 0);
    check("rst_en",    32'(isram_en), 0);
    check("rst_addr",  32'(isram_addr), 0);
    check("rst_valid", 32'(inst_valid), 0);
    check("rst_inst",  32'(inst), 0);
    check("rst_pc",    32'(inst_pc), 0);
    check("rst_state", 32'(dut_state), 32'(IDLE));
    rst = 1'b1;

    // 1: straight-line program, ready always high, latency and done timing
    exp_run(16'h0010, 16'h0800, 6);
    run_prog(16'h0010, 0, 0, 0, '0, '0, 1, fv, fe, fa, da);
    check("t1_first_en", 32'(fe), 1);
    check("t1_first_addr", 32'(fa), 32'h0010);
    check("t1_first_valid", 32'(fv), 3);
    check("t1_done_at", 32'(da), 10);
    @(negedge clk);
    start = 1'b0;
    #2;
    check("t1_done_pulse", 32'(done), 0);
    check("t1_start_in_done_ignored", 32'(busy), 0);
    check("t1_idle_no_issue", 32'(isram_en), 0);

    // 2: random back-pressure, start while busy ignored
    exp_run(16'h0010, 16'h0800, 6);
    run_prog(16'h0010, 1, 0, 0, '0, '0, 0, fv, fe, fa, da);

    // 3: buffer filled, JUMP at 0x0013 back to 0x0011 (HALT response killed too)
    exp_run(16'h0010, 16'h0800, 4);
    exp_run(16'h0011, 16'h0801, 5);
    run_prog(16'h0010, 0, 8, 1, 16'h0013, 16'h0011, 0, fv, fe, fa, da);
    check("t3_done_at", 32'(da), 20);

    // 4: redirect in the cycle the HALT response returns
    exp_run(16'h0010, 16'h0800, 6);
    exp_run(16'h0020, 16'h0900, 2);
    run_prog(16'h0010, 0, 0, 1, 16'h0015, 16'h0020, 0, fv, fe, fa, da);
    check("t4_done_at", 32'(da), 14);

    // 5: address wrap
    exp_run(16'hFFFE, 16'h0A00, 3);
    run_prog(16'hFFFE, 0, 0, 0, '0, '0, 0, fv, fe, fa, da);
    check("t5_first_addr", 32'(fa), 32'hFFFE);
    check("t5_done_at", 32'(da), 7);

    // redirect while idle is ignored
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 16'h0030;
    @(negedge clk);
    redirect = 1'b0;
    #2;
    check("idle_redir_busy", 32'(busy), 0);
    check("idle_redir_state", 32'(dut_state), 32'(IDLE));

    // 6: asynchronous reset with a full buffer
    @(negedge clk);
    start = 1'b1; start_pc = 16'h0010; inst_ready = 1'b0;
    repeat (8) begin @(negedge clk); start = 1'b0; end
    #2;
    check("t6_full_valid", 32'(inst_valid), 1);
    check("t6_full_no_issue", 32'(isram_en), 0);
    check("t6_full_head_pc", 32'(inst_pc), 32'h0010);
    rst = 1'b0;
    #1;
    check("t6_busy",  32'(busy), 0);
    check("t6_done",  32'(done), 0);
    check("t6_en",    32'(isram_en), 0);
    check("t6_addr",  32'(isram_addr), 0);
    check("t6_valid", 32'(inst_valid), 0);
    check("t6_inst",  32'(inst), 0);
    check("t6_pc",    32'(inst_pc), 0);
    check("t6_state", 32'(dut_state), 32'(IDLE));
    repeat (2) @(negedge clk);
    rst = 1'b1; inst_ready = 1'b1;
    exp_q.push_back({16'h0000, 16'h0A02});
    run_prog(16'h0000, 0, 0, 0, '0, '0, 0, fv, fe, fa, da);
    check("t6_first_addr", 32'(fa), 32'h0000);
    check("t6_done_at", 32'(da), 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
